color_id_compositor: RTL and testbench

- Per-pixel scene compositor placed directly upstream of the palette lookup.
- Takes the VGA scan position and produces the 6-bit ColorId that the palette converts to RGB.
- Draws, in priority order: HP bar, player sprite (read from an external synchronous sprite ROM), then background.
- Contains a frame-counted hit-flash controller and latches the player position once per frame so the sprite does not tear.

---
 rtl/color_id_compositor_pkg.sv | 17 +
 rtl/color_id_compositor_hit_flash_ctrl.sv | 49 ++++
 rtl/color_id_compositor.sv | 154 +++++++++++++++
 tb/tb_color_id_compositor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/color_id_compositor_pkg.sv
// Shared palette indices and types for the ColorId compositor.
package zc_color_pkg;

  typedef logic [5:0] color_id_t;

  localparam color_id_t  COL_BLACK     = 6'd0;
  localparam color_id_t  COL_BG        = 6'd22;
  localparam color_id_t  COL_HP        = 6'd23;
  localparam color_id_t  COL_RED       = 6'd24;
  localparam logic [4:0] TRANSP_ID_DEF = 5'd31;

  typedef enum logic {
    FL_IDLE  = 1'b0,
    FL_FLASH = 1'b1
  } flash_state_t;

endpackage

// File: rtl/color_id_compositor_hit_flash_ctrl.sv
// Hit-flash controller: counts down frames after a hit and blinks on odd counts.
module hit_flash_ctrl
  import zc_color_pkg::*;
#(
  parameter int FLASH_FRAMES = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic hit,
  input  logic frame_start,
  output logic flash_on
);

  flash_state_t state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         flash_on_q, flash_on_d;

  // Next-state: a hit always reloads (even over frame_start); frames count down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hit) begin
      cnt_d   = 4'(FLASH_FRAMES);
      state_d = FL_FLASH;
    end else if (frame_start && (state_q == FL_FLASH)) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_d == 4'd0) begin
        state_d = FL_IDLE;
      end
    end
    flash_on_d = (state_d == FL_FLASH) && cnt_d[0];
  end

  // State, counter and registered blink output.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= FL_IDLE;
      cnt_q      <= 4'd0;
      flash_on_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flash_on_q <= flash_on_d;
    end
  end

  assign flash_on = flash_on_q;

endmodule

// File: rtl/color_id_compositor.sv
// Per-pixel compositor: HP bar over player sprite over background, latency 3.
module color_id_compositor
  import zc_color_pkg::*;
#(
  parameter int SPR_W        = 32,
  parameter int SPR_H        = 32,
  parameter int ADDR_W       = 10,
  parameter int HP_X0        = 20,
  parameter int HP_Y0        = 10,
  parameter int HP_H         = 8,
  parameter int HP_MAX       = 100,
  parameter int FLASH_FRAMES = 8,
  parameter int TRANSP_ID    = 31
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        player_x,
  input  logic [9:0]        player_y,
  input  logic [6:0]        hp,
  input  logic              hit,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [4:0]        rom_data,
  output logic [5:0]        ColorId,
  output logic              ColorId_valid
);

  localparam logic [11:0] HP_X_LO = 12'(HP_X0);
  localparam logic [11:0] HP_X_HI = 12'(HP_X0 + 2 * HP_MAX);
  localparam logic [11:0] HP_Y_LO = 12'(HP_Y0);
  localparam logic [11:0] HP_Y_HI = 12'(HP_Y0 + HP_H);
  localparam logic [6:0]  HP_CAP  = 7'(HP_MAX);
  localparam logic [4:0]  TRANSP  = 5'(TRANSP_ID);

  logic              flash_on;

  logic [9:0]        px_q, px_d, py_q, py_d;
  logic signed [10:0] dx, dy;
  logic              in_spr, in_hp, hp_green;
  logic [6:0]        hp_c;
  logic [11:0]       hp_limit, x12, y12;

  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic              in_spr_p1_q, in_spr_p1_d, in_spr_p2_q, in_spr_p2_d;
  logic              in_hp_p1_q, in_hp_p1_d, in_hp_p2_q, in_hp_p2_d;
  logic              green_p1_q, green_p1_d, green_p2_q, green_p2_d;
  color_id_t         color_p3_q, color_p3_d;
  logic              vld_p3_q, vld_p3_d;

  hit_flash_ctrl #(
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_flash (
    .Clk        (Clk),
    .Reset      (Reset),
    .hit        (hit),
    .frame_start(frame_start),
    .flash_on   (flash_on)
  );

  // Latch the player position once per frame so the sprite never tears.
  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (frame_start) begin
      px_d = player_x;
      py_d = player_y;
    end
  end

  // S1: geometry tests and sprite ROM address.
  always_comb begin
    dx       = $signed({1'b0, DrawX}) - $signed({1'b0, px_q});
    dy       = $signed({1'b0, DrawY}) - $signed({1'b0, py_q});
    in_spr   = !dx[10] && (dx[9:0] < 10'(SPR_W)) &&
               !dy[10] && (dy[9:0] < 10'(SPR_H));
    x12      = {2'b00, DrawX};
    y12      = {2'b00, DrawY};
    in_hp    = (y12 >= HP_Y_LO) && (y12 < HP_Y_HI) &&
               (x12 >= HP_X_LO) && (x12 < HP_X_HI);
    hp_c     = (hp > HP_CAP) ? HP_CAP : hp;
    hp_limit = HP_X_LO + {4'b0000, hp_c, 1'b0};
    hp_green = x12 < hp_limit;

    rom_addr_d  = rom_addr_q;
    if (in_spr) begin
      rom_addr_d = ADDR_W'(32'(dy[9:0]) * SPR_W + 32'(dx[9:0]));
    end
    vld_p1_d    = pix_valid;
    in_spr_p1_d = in_spr;
    in_hp_p1_d  = in_hp;
    green_p1_d  = hp_green;
  end

  // S2: ROM data arrives; flags wait one stage to line up with it.
  always_comb begin
    vld_p2_d    = vld_p1_q;
    in_spr_p2_d = in_spr_p1_q;
    in_hp_p2_d  = in_hp_p1_q;
    green_p2_d  = green_p1_q;
  end

  // S3: priority select HP bar > opaque sprite > background.
  always_comb begin
    vld_p3_d   = vld_p2_q;
    color_p3_d = COL_BG;
    if (!vld_p2_q) begin
      color_p3_d = COL_BLACK;
    end else if (in_hp_p2_q) begin
      color_p3_d = green_p2_q ? COL_HP : COL_RED;
    end else if (in_spr_p2_q && (rom_data != TRANSP)) begin
      color_p3_d = flash_on ? COL_RED : {1'b0, rom_data};
    end
  end

  // Control state: position latch, ROM address, valid chain and output.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      px_q       <= 10'd0;
      py_q       <= 10'd0;
      rom_addr_q <= '0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      vld_p3_q   <= 1'b0;
      color_p3_q <= COL_BLACK;
    end else begin
      px_q       <= px_d;
      py_q       <= py_d;
      rom_addr_q <= rom_addr_d;
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      vld_p3_q   <= vld_p3_d;
      color_p3_q <= color_p3_d;
    end
  end

  // Data flags ride alongside the valid chain and need no reset.
  always_ff @(posedge Clk) begin
    in_spr_p1_q <= in_spr_p1_d;
    in_hp_p1_q  <= in_hp_p1_d;
    green_p1_q  <= green_p1_d;
    in_spr_p2_q <= in_spr_p2_d;
    in_hp_p2_q  <= in_hp_p2_d;
    green_p2_q  <= green_p2_d;
  end

  assign rom_addr      = rom_addr_q;
  assign ColorId       = color_p3_q;
  assign ColorId_valid = vld_p3_q;

endmodule

// File: tb/tb_color_id_compositor.sv
// Directed bench for color_id_compositor with a synchronous sprite ROM model.
module tb_color_id_compositor;

  logic       clk;
  logic       rst;
  logic       frame_start;
  logic       pix_valid;
  logic [9:0] draw_x, draw_y;
  logic [9:0] player_x, player_y;
  logic [6:0] hp;
  logic       hit;
  logic [9:0] rom_addr;
  logic [4:0] rom_data;
  logic [5:0] color_id;
  logic       color_vld;

  logic [4:0] rom_mem [0:1023];

  int n_cmp = 0;
  int n_bad = 0;

  color_id_compositor dut (
    .Clk          (clk),
    .Reset        (rst),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .DrawX        (draw_x),
    .DrawY        (draw_y),
    .player_x     (player_x),
    .player_y     (player_y),
    .hp           (hp),
    .hit          (hit),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .ColorId      (color_id),
    .ColorId_valid(color_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom_mem[rom_addr];

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [6:0] hpv;
    logic       pv;
    int         addr;
    logic [4:0] rv;
    logic [5:0] ec;
    logic       ev;
    string      nm;
  } vec_t;

  vec_t tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic pv);
    draw_x    = 10'(x);
    draw_y    = 10'(y);
    pix_valid = pv;
  endtask

  task automatic latch_pos(input int x, input int y);
    logic pv_save;
    pv_save     = pix_valid;
    pix_valid   = 1'b0;
    player_x    = 10'(x);
    player_y    = 10'(y);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pix_valid   = pv_save;
  endtask

  task automatic frame_pulse(input logic with_hit);
    pix_valid   = 1'b0;
    frame_start = 1'b1;
    hit         = with_hit;
    step();
    frame_start = 1'b0;
    hit         = 1'b0;
    pix_valid   = 1'b1;
  endtask

  task automatic settle_and_check(input string nm, input int exp);
    step(); step(); step();
    check(nm, int'(color_id), exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = 5'd5;
    rst = 1'b1; frame_start = 1'b0; hit = 1'b0; hp = 7'd40;
    player_x = '0; player_y = '0;
    pix(105, 102, 1'b1);

    tbl[0]  = '{10'd105, 10'd102, 7'd40,  1'b1, 69,   5'd7,  6'd7,  1'b1, "spr_opaque"};
    tbl[1]  = '{10'd105, 10'd102, 7'd40,  1'b1, 69,   5'd31, 6'd22, 1'b1, "spr_transp"};
    tbl[2]  = '{10'd99,  10'd12,  7'd40,  1'b1, -1,   5'd0,  6'd23, 1'b1, "hp40_x99"};
    tbl[3]  = '{10'd100, 10'd12,  7'd40,  1'b1, -1,   5'd0,  6'd24, 1'b1, "hp40_x100"};
    tbl[4]  = '{10'd219, 10'd12,  7'd40,  1'b1, -1,   5'd0,  6'd24, 1'b1, "hp40_x219"};
    tbl[5]  = '{10'd220, 10'd12,  7'd40,  1'b1, -1,   5'd0,  6'd22, 1'b1, "hp40_x220"};
    tbl[6]  = '{10'd219, 10'd12,  7'd120, 1'b1, -1,   5'd0,  6'd23, 1'b1, "hp120_x219"};
    tbl[7]  = '{10'd20,  10'd10,  7'd0,   1'b1, -1,   5'd0,  6'd24, 1'b1, "hp0_x20"};
    tbl[8]  = '{10'd20,  10'd17,  7'd100, 1'b1, -1,   5'd0,  6'd23, 1'b1, "hp100_y17"};
    tbl[9]  = '{10'd20,  10'd18,  7'd100, 1'b1, -1,   5'd0,  6'd22, 1'b1, "below_bar"};
    tbl[10] = '{10'd19,  10'd12,  7'd40,  1'b1, -1,   5'd0,  6'd22, 1'b1, "left_of_bar"};
    tbl[11] = '{10'd105, 10'd102, 7'd40,  1'b0, -1,   5'd0,  6'd0,  1'b0, "pix_invalid"};
    tbl[12] = '{10'd131, 10'd131, 7'd40,  1'b1, 1023, 5'd12, 6'd12, 1'b1, "spr_corner"};
    tbl[13] = '{10'd132, 10'd131, 7'd40,  1'b1, -1,   5'd0,  6'd22, 1'b1, "spr_right_out"};

    // Reset state
    for (int i = 0; i < 5; i++) step();
    check("rst_color", int'(color_id), 0);
    check("rst_valid", int'(color_vld), 0);
    check("rst_addr", int'(rom_addr), 0);
    rst = 1'b0;

    // Table of single-pixel vectors with sprite at (100,100)
    latch_pos(100, 100);
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].addr >= 0) rom_mem[tbl[i].addr] = tbl[i].rv;
      hp = tbl[i].hpv;
      pix(int'(tbl[i].x), int'(tbl[i].y), tbl[i].pv);
      step();
      if (tbl[i].addr >= 0) check({tbl[i].nm, "_addr"}, int'(rom_addr), tbl[i].addr);
      step(); step();
      check(tbl[i].nm, int'(color_id), int'(tbl[i].ec));
      check({tbl[i].nm, "_vld"}, int'(color_vld), int'(tbl[i].ev));
    end

    // Sprite crossing the right edge: no wrap onto the left of the screen
    hp = 7'd40;
    latch_pos(630, 100);
    rom_mem[105] = 5'd9;
    pix(639, 103, 1'b1);
    step();
    check("clip_addr", int'(rom_addr), 105);
    step(); step();
    check("clip_x639", int'(color_id), 9);
    pix(5, 103, 1'b1);
    step();
    check("clip_addr_hold", int'(rom_addr), 105);
    step(); step();
    check("clip_x5", int'(color_id), 22);

    // Sprite under the HP bar: HP wins
    latch_pos(20, 0);
    rom_mem[394] = 5'd7;
    pix(30, 12, 1'b1);
    step();
    check("ovl_addr", int'(rom_addr), 394);
    step(); step();
    check("ovl_hp_wins", int'(color_id), 23);

    // Hit flash: blink on odd counts, idle after FLASH_FRAMES frames
    latch_pos(100, 100);
    rom_mem[69] = 5'd7;
    pix(105, 102, 1'b1);
    hit = 1'b1; step(); hit = 1'b0;
    settle_and_check("flash_cnt8", 7);
    for (int k = 1; k <= 8; k++) begin
      frame_pulse(1'b0);
      settle_and_check($sformatf("flash_cnt%0d", 8 - k), ((8 - k) % 2 == 1) ? 24 : 7);
    end
    hit = 1'b1; step(); hit = 1'b0;
    for (int k = 0; k < 5; k++) frame_pulse(1'b0);
    settle_and_check("retrig_cnt3", 24);
    frame_pulse(1'b1);
    settle_and_check("reload_cnt8", 7);
    frame_pulse(1'b0);
    settle_and_check("reload_cnt7", 24);
    frame_pulse(1'b0);
    settle_and_check("reload_cnt6", 7);
    frame_pulse(1'b0);
    settle_and_check("reload_cnt5", 24);

    // Mid-scan reset: flush, 3-cycle refill, position and flash cleared
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("mrst_color", int'(color_id), 0);
    check("mrst_valid", int'(color_vld), 0);
    rst = 1'b0;
    step();
    check("rel1_valid", int'(color_vld), 0);
    step();
    check("rel2_valid", int'(color_vld), 0);
    check("rel2_color", int'(color_id), 0);
    step();
    check("rel3_valid", int'(color_vld), 1);
    check("rel3_color_px0", int'(color_id), 22);
    latch_pos(100, 100);
    settle_and_check("post_rst_noflash", 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
